// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter: round-robin owner of the shared single-port data memory.
// Revision: 1.0
// ============================================================================
module memory_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int HOLD_LIMIT = 64
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [NUM_REQ-1:0]            i_Request,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_Address,
  input  logic [NUM_REQ-1:0]            i_Write_Enable,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Write_Data,
  input  logic [DATA_WIDTH-1:0]         i_Mem_Read_Data,
  output logic [NUM_REQ-1:0]            o_Grant,
  output logic [ADDR_WIDTH-1:0]         o_Mem_Address,
  output logic                          o_Mem_Write_Enable,
  output logic [DATA_WIDTH-1:0]         o_Mem_Write_Data,
  output logic [DATA_WIDTH-1:0]         o_Read_Data,
  output logic [$clog2(NUM_REQ)-1:0]    o_Owner,
  output logic                          o_Busy,
  output logic                          o_Hold_Violation
);

  localparam int c_OWNER_W = $clog2(NUM_REQ);
  localparam int c_HOLD_W  = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [c_HOLD_W-1:0]  c_HOLD_MAX  = c_HOLD_W'(HOLD_LIMIT);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_TRIP = c_HOLD_W'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);
  localparam logic [c_OWNER_W-1:0] c_LAST      = c_OWNER_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  state_t                 r_State;
  logic [c_OWNER_W-1:0]   r_Ptr;
  logic [c_HOLD_W-1:0]    r_Hold_Count;

  logic [c_OWNER_W-1:0]   w_Sel;
  logic [NUM_REQ-1:0]     w_Sel_Onehot;
  int                     w_Idx;

  // Scan downward so the requester closest to the pointer is written last and wins.
  always_comb begin
    w_Sel = '0;
    w_Idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_Idx = int'(r_Ptr) + i;
      if (w_Idx >= NUM_REQ) begin
        w_Idx = w_Idx - NUM_REQ;
      end
      if (i_Request[w_Idx]) begin
        w_Sel = c_OWNER_W'(w_Idx);
      end
    end
    w_Sel_Onehot = NUM_REQ'(1) << w_Sel;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State          <= S_IDLE;
      r_Ptr            <= '0;
      r_Hold_Count     <= '0;
      o_Grant          <= '0;
      o_Owner          <= '0;
      o_Busy           <= 1'b0;
      o_Hold_Violation <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (|i_Request) begin
            o_Grant      <= w_Sel_Onehot;
            o_Owner      <= w_Sel;
            o_Busy       <= 1'b1;
            r_Hold_Count <= '0;
            r_State      <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (i_Request[o_Owner]) begin
            if (r_Hold_Count != c_HOLD_MAX) begin
              r_Hold_Count <= r_Hold_Count + c_HOLD_W'(1);
            end
            // Flag is raised on the edge the count reaches the limit; the grant is kept.
            if ((HOLD_LIMIT != 0) && (r_Hold_Count >= c_HOLD_TRIP)) begin
              o_Hold_Violation <= 1'b1;
            end
          end else begin
            o_Grant <= '0;
            o_Busy  <= 1'b0;
            r_Ptr   <= (o_Owner == c_LAST) ? '0 : o_Owner + c_OWNER_W'(1);
            r_State <= S_IDLE;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Mem_Address      = o_Busy ? i_Address[int'(o_Owner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_Mem_Write_Enable = o_Busy & i_Write_Enable[o_Owner];
  assign o_Mem_Write_Data   = o_Busy ? i_Write_Data[int'(o_Owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_Read_Data        = i_Mem_Read_Data;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_memory_arbiter: directed and randomized checks of memory_arbiter.
// Revision: 1.0
// ============================================================================
module tb_memory_arbiter;

  localparam int N  = 5;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int HL = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    we;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata;

  logic [N-1:0]    grant;
  logic [AW-1:0]   maddr;
  logic            mwe;
  logic [DW-1:0]   mwdata;
  logic [DW-1:0]   rd;
  logic [2:0]      owner;
  logic            busy;
  logic            viol;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit   m_busy;
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  bit   m_viol;
  int   waits [N];
  int   rem   [N];
  logic [N-1:0] prev_grant;
  logic [N-1:0] req_at_edge;
  int   exp_order [5] = '{0, 1, 4, 0, 1};

  always #5 clk = ~clk;

  memory_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .HOLD_LIMIT(HL)
  ) dut (
    .i_Clock           (clk),
    .i_Reset           (rst),
    .i_Request         (req),
    .i_Address         (addr),
    .i_Write_Enable    (we),
    .i_Write_Data      (wdata),
    .i_Mem_Read_Data   (rdata),
    .o_Grant           (grant),
    .o_Mem_Address     (maddr),
    .o_Mem_Write_Enable(mwe),
    .o_Mem_Write_Data  (mwdata),
    .o_Read_Data       (rd),
    .o_Owner           (owner),
    .o_Busy            (busy),
    .o_Hold_Violation  (viol)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert ($onehot0(grant)) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=one-hot-or-zero", grant);
    end
  end

  function automatic void model_reset();
    m_busy     = 1'b0;
    m_owner    = 0;
    m_ptr      = 0;
    m_hold     = 0;
    m_viol     = 1'b0;
    prev_grant = '0;
    for (int k = 0; k < N; k++) begin
      waits[k] = 0;
      rem[k]   = 0;
    end
  endfunction

  // Spec rules applied to the request vector seen at a clock edge.
  function automatic void model_edge();
    if (!m_busy) begin
      if (req != '0) begin
        int sel;
        sel = -1;
        for (int i = 0; i < N && sel < 0; i++) begin
          if (req[(m_ptr + i) % N]) sel = (m_ptr + i) % N;
        end
        m_owner = sel;
        m_busy  = 1'b1;
        m_hold  = 0;
      end
    end else if (req[m_owner]) begin
      m_hold++;
      if (HL != 0 && m_hold >= HL) m_viol = 1'b1;
    end else begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end
  endfunction

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_busy) begin
      chk("owner", 64'(owner), 64'(m_owner));
      chk("mem_addr", 64'(maddr), 64'(addr[m_owner*AW +: AW]));
      chk("mem_we", 64'(mwe), 64'(we[m_owner]));
      chk("mem_wdata", 64'(mwdata), 64'(wdata[m_owner*DW +: DW]));
    end else begin
      chk("mem_addr_idle", 64'(maddr), 64'd0);
      chk("mem_we_idle", 64'(mwe), 64'd0);
      chk("mem_wdata_idle", 64'(mwdata), 64'd0);
    end
    chk("hold_viol", 64'(viol), 64'(m_viol));
    chk("read_data", 64'(rd), 64'(rdata));
  endtask

  // Fairness bookkeeping from the DUT's own grant edges.
  task automatic fairness_update();
    if (grant != '0 && prev_grant == '0) begin
      for (int j = 0; j < N; j++) begin
        if (grant[j]) begin
          waits[j] = 0;
        end else if (req_at_edge[j]) begin
          waits[j]++;
          chk("fairness", 64'(waits[j] <= N - 1), 64'd1);
        end
      end
    end
    prev_grant = grant;
  endtask

  task automatic cyc();
    @(posedge clk);
    req_at_edge = req;
    model_edge();
    #1;
    check_all();
    fairness_update();
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    apply_reset();
    #1;
    check_all();

    // Idle datapath: read data passes through, memory controls stay quiet.
    for (int k = 0; k < N; k++) begin
      addr[k*AW +: AW]  = AW'($urandom | 1);
      wdata[k*DW +: DW] = $urandom;
    end
    we    = '1;
    rdata = 32'hDEADBEEF;
    #1;
    chk("idle_read_data", 64'(rd), 64'h0DEADBEEF);
    chk("idle_addr", 64'(maddr), 64'd0);
    chk("idle_we", 64'(mwe), 64'd0);
    cyc();

    // Round-robin order with constant request set.
    apply_reset();
    req = 5'b10011;
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk("rr_order", 64'(owner), 64'(exp_order[g]));
      cyc();
      cyc();
      req[exp_order[g]] = 1'b0;
      cyc();
      chk("turnaround_idle", 64'(busy), 64'd0);
      req = 5'b10011;
    end

    // Non-owner strobes have no effect.
    apply_reset();
    req = 5'b00010;
    addr[AW +: AW] = 10'h155;
    addr[0 +: AW]  = 10'h3FF;
    we = 5'b00011;
    wdata[0 +: DW]  = 32'h11111111;
    wdata[DW +: DW] = 32'hA5A5_5A5A;
    cyc();
    chk("owner1", 64'(owner), 64'd1);
    chk("owner1_addr", 64'(maddr), 64'h155);
    chk("owner1_we", 64'(mwe), 64'd1);
    chk("owner1_wdata", 64'(mwdata), 64'hA5A55A5A);
    we = 5'b00001;
    #1;
    chk("nonowner_we", 64'(mwe), 64'd0);
    req = '0;
    cyc();

    // Release and new request on the same edge.
    apply_reset();
    req = 5'b01000;
    cyc();
    cyc();
    req = 5'b00001;
    cyc();
    chk("swap_idle_grant", 64'(grant), 64'd0);
    chk("swap_idle_busy", 64'(busy), 64'd0);
    cyc();
    chk("swap_grant", 64'(grant), 64'b00001);
    chk("swap_owner", 64'(owner), 64'd0);
    req = '0;
    cyc();

    // Hold violation after HL cycles; grant kept, flag sticky.
    apply_reset();
    req = 5'b00001;
    cyc();
    for (int k = 1; k < 12; k++) begin
      cyc();
      chk("hold_flag", 64'(viol), 64'(k >= HL));
      chk("hold_grant", 64'(grant), 64'b00001);
    end
    req = '0;
    cyc();
    chk("hold_release", 64'(busy), 64'd0);
    repeat (3) cyc();
    chk("hold_sticky", 64'(viol), 64'd1);

    // Asynchronous reset mid-grant with owner 2.
    req = 5'b00100;
    cyc();
    cyc();
    chk("pre_reset_owner", 64'(owner), 64'd2);
    rst = 1'b1;
    #1;
    chk("async_grant", 64'(grant), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_viol", 64'(viol), 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc();
    chk("post_reset_grant", 64'(grant), 64'b00100);
    req = '0;
    cyc();

    // Randomized requesters that hold until granted, then release after a few cycles.
    apply_reset();
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        if (m_busy && m_owner == k) begin
          if (rem[k] == 0) req[k] = 1'b0;
          else rem[k]--;
        end else if (!req[k] && ($urandom % 3 == 0)) begin
          req[k] = 1'b1;
          rem[k] = $urandom_range(0, 4);
        end
        addr[k*AW +: AW]  = AW'($urandom);
        wdata[k*DW +: DW] = $urandom;
      end
      we    = N'($urandom);
      rdata = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
